// File: rtl/sum_accumulator.sv
// sum_accumulator: collects COUNT unsigned sums per batch and hands the total downstream with valid/ready.
// Optional macro SUM_ACC_SAT_EN: an overflowing addition clamps the total instead of wrapping.
`default_nettype none

module sum_accumulator #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4,
  parameter int ACC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   x_in,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               accept;
  logic [ACC_W:0]     sum;
  logic               carry;

  // x_ready is gated by rst so it drops the instant reset is applied.
  assign x_ready   = (state_q == ACCUM) && !rst;
  assign accept    = x_valid && x_ready;
  assign sum       = {1'b0, acc_q} + (ACC_W + 1)'(x_in);
  assign carry     = sum[ACC_W];

  assign acc_out   = acc_q;
  assign acc_valid = (state_q == DONE);
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          ovf_d = ovf_q | carry;
`ifdef SUM_ACC_SAT_EN
          acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Handoff clears the batch; a simultaneous x_valid is not taken.
        if (acc_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: drives a COUNT=4 and a COUNT=8 instance with shared stimulus against a batch-sum model.
`default_nettype none

module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] x_in = '0;
  logic       x_valid = 1'b0;
  logic       acc_ready = 1'b0;

  logic       x_ready4, acc_valid4, ovf4;
  logic [6:0] acc_out4;
  logic       x_ready8, acc_valid8, ovf8;
  logic [6:0] acc_out8;

  int n_checks = 0;
  int n_err    = 0;

  // Model: true (unbounded) batch sum, accept count, and whether a result is held.
  int m_sum  [2];
  int m_n    [2];
  bit m_done [2];

  always #5 clk = ~clk;

  sum_accumulator #(.WIDTH(4), .COUNT(4), .ACC_W(7)) u_dut4 (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready4),
    .acc_out(acc_out4), .acc_valid(acc_valid4), .acc_ready(acc_ready), .ovf(ovf4)
  );

  sum_accumulator #(.WIDTH(4), .COUNT(8), .ACC_W(7)) u_dut8 (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready8),
    .acc_out(acc_out8), .acc_valid(acc_valid8), .acc_ready(acc_ready), .ovf(ovf8)
  );

  function automatic int exp_acc(input int s);
`ifdef SUM_ACC_SAT_EN
    return (s > 127) ? 127 : s;
`else
    return s % 128;
`endif
  endfunction

  function automatic int batch_len(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("acc_out4",   32'(acc_out4),   32'(exp_acc(m_sum[0])));
    chk("acc_valid4", 32'(acc_valid4), 32'(m_done[0]));
    chk("ovf4",       32'(ovf4),       32'(m_sum[0] > 127));
    chk("acc_out8",   32'(acc_out8),   32'(exp_acc(m_sum[1])));
    chk("acc_valid8", 32'(acc_valid8), 32'(m_done[1]));
    chk("ovf8",       32'(ovf8),       32'(m_sum[1] > 127));
  endtask

  task automatic step(input bit v, input logic [4:0] x, input bit r);
    bit held;
    x_valid   = v;
    x_in      = x;
    acc_ready = r;
    chk("x_ready4", 32'(x_ready4), 32'(!m_done[0]));
    chk("x_ready8", 32'(x_ready8), 32'(!m_done[1]));
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      held = m_done[k];
      if (!held && v) begin
        m_sum[k] += int'(x);
        m_n[k]++;
        if (m_n[k] == batch_len(k)) m_done[k] = 1'b1;
      end else if (held && r) begin
        m_sum[k]  = 0;
        m_n[k]    = 0;
        m_done[k] = 1'b0;
      end
    end
    check_outputs();
  endtask

  // Asserts rst between edges, checks the immediate clear, then releases after an edge.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      m_sum[k] = 0; m_n[k] = 0; m_done[k] = 1'b0;
    end
    check_outputs();
    chk("rst_x_ready4", 32'(x_ready4), 32'd0);
    chk("rst_x_ready8", 32'(x_ready8), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rel_x_ready4", 32'(x_ready4), 32'd1);
    chk("rel_x_ready8", 32'(x_ready8), 32'd1);
  endtask

  initial begin
    int accepts;
    logic [4:0] rx;

    pulse_reset();

    // Basic batch 0,2,4,6 with downstream always ready.
    step(1, 5'd0, 1); step(1, 5'd2, 1); step(1, 5'd4, 1); step(1, 5'd6, 1);
    chk("basic_valid", 32'(acc_valid4), 32'd1);
    chk("basic_total", 32'(acc_out4), 32'd12);
    chk("basic_ovf", 32'(ovf4), 32'd0);
    step(0, 5'd0, 1);
    chk("basic_ready_after", 32'(x_ready4), 32'd1);

    // Backpressure: result must hold while x_valid stays high.
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1, 5'd30, 0);
    for (int i = 0; i < 5; i++) step(1, 5'd30, 0);
    chk("bp_total", 32'(acc_out4), 32'd120);
    chk("bp_x_ready", 32'(x_ready4), 32'd0);
    step(1, 5'd30, 1);
    chk("bp_handoff_valid", 32'(acc_valid4), 32'd0);
    step(1, 5'd1, 0);
    chk("bp_restart", 32'(acc_out4), 32'd1);

    // Gapped input.
    pulse_reset();
    accepts = 0;
    begin
      bit pat [6] = '{1, 0, 1, 1, 0, 1};
      for (int i = 0; i < 6; i++) begin
        if (pat[i] && x_ready4) accepts++;
        step(pat[i], 5'd5, 0);
      end
    end
    chk("gap_accepts", 32'(accepts), 32'd4);
    chk("gap_total", 32'(acc_out4), 32'd20);

    // Overflow on the COUNT=8 instance.
    pulse_reset();
    for (int i = 0; i < 8; i++) step(1, 5'd30, 0);
`ifdef SUM_ACC_SAT_EN
    chk("ovf8_total", 32'(acc_out8), 32'd127);
`else
    chk("ovf8_total", 32'(acc_out8), 32'd112);
`endif
    chk("ovf8_flag", 32'(ovf8), 32'd1);
    chk("ovf8_valid", 32'(acc_valid8), 32'd1);
    step(0, 5'd0, 1);

    // Mid-batch reset discards the partial batch.
    pulse_reset();
    step(1, 5'd7, 0); step(1, 5'd7, 0);
    pulse_reset();
    step(1, 5'd1, 0); step(1, 5'd2, 0); step(1, 5'd3, 0); step(1, 5'd4, 0);
    chk("midrst_total", 32'(acc_out4), 32'd10);
    chk("midrst_ovf", 32'(ovf4), 32'd0);
    step(0, 5'd0, 1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        pulse_reset();
      end else begin
        rx = 5'($urandom_range(0, 31));
        step(bit'($urandom_range(0, 3) != 0), rx, bit'($urandom_range(0, 2) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the adder operand width; input sums are WIDTH+1 bits.
REQ-002 The block SHALL have parameter COUNT, default 4, the number of sums per batch; legal range COUNT >= 2.
REQ-003 The block SHALL have parameter ACC_W, default 7, the accumulator width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 x_in  input  WIDTH+1  sum from the adder stage, unsigned.
REQ-007 x_valid  input  1  x_in valid this cycle.
REQ-008 x_ready  output  1  block accepts x_in this cycle.
REQ-009 acc_out  output  ACC_W  batch total.
REQ-010 acc_valid  output  1  acc_out holds a completed batch.
REQ-011 acc_ready  input  1  downstream takes acc_out this cycle.
REQ-012 ovf  output  1  batch total exceeded 2^ACC_W-1.

Function
REQ-013 The FSM SHALL have exactly two states: ACCUM (collecting) and DONE (holding a result).
REQ-014 A sample SHALL be accepted only in a cycle where x_valid and x_ready are both 1; no other cycle changes the accumulator or the sample counter.
REQ-015 x_ready SHALL be 1 exactly when state is ACCUM and rst is 0.
REQ-016 On each acceptance, acc SHALL become acc + zero-extended x_in, and the sample counter ($clog2(COUNT) bits) SHALL increment.
REQ-017 On the COUNT-th acceptance, the FSM SHALL go ACCUM->DONE; acc_valid SHALL be 1 in the cycle after that acceptance (latency 1 cycle).
REQ-018 In DONE, acc_out and ovf SHALL hold stable and x_ready SHALL be 0 until acc_ready is 1.
REQ-019 In DONE with acc_ready=1, the next edge SHALL clear acc, the counter and ovf, and go to ACCUM; acc_valid is 0 from that cycle.
REQ-020 In DONE with acc_ready=1 and x_valid=1 in the same cycle, x_in SHALL NOT be accepted (no bypass).
REQ-021 acc_ready SHALL be ignored in ACCUM.
REQ-022 ovf SHALL be set when any addition in the batch carries out of ACC_W bits; it is sticky until the batch handoff.
REQ-023 acc_out SHALL show the running total in ACCUM and SHALL be meaningful to downstream only while acc_valid=1.

Reset
REQ-024 While rst=1, outputs SHALL be acc_out=0, acc_valid=0, ovf=0, x_ready=0; the counter SHALL be 0 and the state ACCUM.
REQ-025 Reset SHALL take effect immediately regardless of clk, including mid-batch or in DONE; a partial batch is discarded.
REQ-026 x_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 With macro SUM_ACC_SAT_EN defined, an overflowing addition SHALL clamp acc to 2^ACC_W-1 and keep it there for the rest of the batch; ovf behaviour is unchanged.
REQ-028 Without SUM_ACC_SAT_EN, the accumulator SHALL wrap modulo 2^ACC_W.

Verification (WIDTH=4, COUNT=4, ACC_W=7 unless stated)
REQ-029 Reset check: assert rst mid-run -> acc_out=0, acc_valid=0, ovf=0, x_ready=0 at once; release -> x_ready=1 the next cycle.
REQ-030 Basic batch: sums 0,2,4,6 back-to-back, acc_ready=1 -> acc_valid=1 one cycle after the 4th accept, acc_out=12, ovf=0; x_ready=1 the cycle after handoff.
REQ-031 Backpressure: 30,30,30,30 with acc_ready=0 for 5 cycles and x_valid held at 1 -> acc_out=120 stable, x_ready=0, no extra accepts; acc_ready=1 -> handoff, counter=0.
REQ-032 Gapped input: x_valid pattern 1,0,1,1,0,1 with x_in=5 every cycle -> exactly 4 accepts, acc_out=20.
REQ-033 Overflow, COUNT=8: eight sums of 30 -> without macro acc_out=112, ovf=1; with SUM_ACC_SAT_EN acc_out=127, ovf=1.
REQ-034 Mid-batch reset: accept 7,7, pulse rst, then accept 1,2,3,4 -> acc_out=10, ovf=0.
